// File: rtl/gf2_mask_share_gen.sv
// Splits an unmasked GF(2^2) operand pair into SHARES Boolean shares plus fresh DOM randomness.
// One-cycle registered latency; the output register holds under stall, and a reseed request blocks accept.
module gf2_mask_share_gen #(
  parameter int          SHARES = 3,
  parameter logic [31:0] SEED   = 32'h0000_0001
) (
  input  logic                         ClkxCI,
  input  logic                         RstxRI,
  input  logic                         InValidxSI,
  output logic                         InReadyxSO,
  input  logic [1:0]                   XxDI,
  input  logic [1:0]                   YxDI,
  input  logic                         SeedValidxSI,
  input  logic [31:0]                  SeedxDI,
  output logic                         OutValidxSO,
  input  logic                         OutReadyxSI,
  output logic [2*SHARES-1:0]          _XxDO,
  output logic [2*SHARES-1:0]          _YxDO,
  output logic [SHARES*(SHARES-1)-1:0] _ZxDO,
  output logic [15:0]                  OpCntxDO
);

  localparam int MW = 2 * (SHARES - 1);
  localparam int ZW = SHARES * (SHARES - 1);

  logic [31:0]         s;
  logic [31:0]         s_step;
  logic                accept;
  logic [2*SHARES-1:0] x_sh;
  logic [2*SHARES-1:0] y_sh;
  logic [1:0]          x0;
  logic [1:0]          y0;
  logic [ZW-1:0]       z_new;

  assign InReadyxSO = !RstxRI && !SeedValidxSI && (!OutValidxSO || OutReadyxSI);
  assign accept     = InValidxSI && InReadyxSO;

  // The step is invertible, so a nonzero state never maps to zero; the guard only backs that up.
  always_comb begin
    s_step = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    if (s_step == 32'd0) s_step = SEED;
  end

  always_comb begin
    x0   = XxDI;
    y0   = YxDI;
    x_sh = '0;
    y_sh = '0;
    for (int k = 1; k < SHARES; k++) begin
      x_sh[2*k +: 2] = s[2*(k-1) +: 2];
      y_sh[2*k +: 2] = s[MW + 2*(k-1) +: 2];
      x0 = x0 ^ s[2*(k-1) +: 2];
      y0 = y0 ^ s[MW + 2*(k-1) +: 2];
    end
    x_sh[1:0] = x0;
    y_sh[1:0] = y0;
  end

  assign z_new = s[2*MW +: ZW];

  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      s           <= SEED;
      OutValidxSO <= 1'b0;
      _XxDO       <= '0;
      _YxDO       <= '0;
      _ZxDO       <= '0;
      OpCntxDO    <= 16'd0;
    end else begin
      if (SeedValidxSI) begin
        s <= (SeedxDI == 32'd0) ? SEED : SeedxDI;
      end else if (accept) begin
        s <= s_step;
      end

      if (accept) begin
        OutValidxSO <= 1'b1;
        _XxDO       <= x_sh;
        _YxDO       <= y_sh;
        _ZxDO       <= z_new;
        OpCntxDO    <= OpCntxDO + 16'd1;
      end else if (OutValidxSO && OutReadyxSI) begin
        OutValidxSO <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gf2_mask_share_gen.sv
// Scoreboard bench for gf2_mask_share_gen with SHARES=3, SEED=1.
module tb_gf2_mask_share_gen;

  localparam logic [31:0] SEED = 32'h0000_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic [1:0]  x_in = '0;
  logic [1:0]  y_in = '0;
  logic        seed_vld = 1'b0;
  logic [31:0] seed_dat = '0;
  logic        out_vld;
  logic        out_rdy = 1'b1;
  logic [5:0]  x_out;
  logic [5:0]  y_out;
  logic [5:0]  z_out;
  logic [15:0] cnt_out;

  typedef struct {
    logic [5:0]  xs;
    logic [5:0]  ys;
    logic [5:0]  z;
    logic [15:0] cnt;
    logic [1:0]  xi;
    logic [1:0]  yi;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_s = SEED;
  logic [15:0] m_cnt = '0;
  int          total = 0;
  int          bad = 0;

  gf2_mask_share_gen #(.SHARES(3), .SEED(SEED)) dut (
    .ClkxCI      (clk),
    .RstxRI      (rst),
    .InValidxSI  (in_vld),
    .InReadyxSO  (in_rdy),
    .XxDI        (x_in),
    .YxDI        (y_in),
    .SeedValidxSI(seed_vld),
    .SeedxDI     (seed_dat),
    .OutValidxSO (out_vld),
    .OutReadyxSI (out_rdy),
    ._XxDO       (x_out),
    ._YxDO       (y_out),
    ._ZxDO       (z_out),
    .OpCntxDO    (cnt_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  // Hand layout for SHARES=3: X masks s[3:0], Y masks s[7:4], Z = s[13:8].
  task automatic push_model(input logic [1:0] x, input logic [1:0] y);
    exp_t e;
    e.xs  = {m_s[3:2], m_s[1:0], x ^ m_s[1:0] ^ m_s[3:2]};
    e.ys  = {m_s[7:6], m_s[5:4], y ^ m_s[5:4] ^ m_s[7:6]};
    e.z   = m_s[13:8];
    m_cnt = m_cnt + 16'd1;
    e.cnt = m_cnt;
    e.xi  = x;
    e.yi  = y;
    sb.push_back(e);
    m_s = lfsr_step(m_s);
  endtask

  task automatic push_const(input logic [1:0] x, input logic [1:0] y,
                            input logic [5:0] xs, input logic [5:0] ys, input logic [5:0] z);
    exp_t e;
    e.xs  = xs;
    e.ys  = ys;
    e.z   = z;
    m_cnt = m_cnt + 16'd1;
    e.cnt = m_cnt;
    e.xi  = x;
    e.yi  = y;
    sb.push_back(e);
    m_s = lfsr_step(m_s);
  endtask

  task automatic wait_accept(input bit must_now);
    int n = 0;
    @(negedge clk);
    while (!in_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready", in_rdy, 1);
    if (must_now) chk("accept_delay", n, 0);
  endtask

  task automatic send(input logic [1:0] x, input logic [1:0] y, input bit must_now);
    in_vld = 1'b1;
    x_in   = x;
    y_in   = y;
    wait_accept(must_now);
    if (in_rdy) push_model(x, y);
    @(posedge clk); #1;
    in_vld = 1'b0;
  endtask

  task automatic send_const(input logic [1:0] x, input logic [1:0] y,
                            input logic [5:0] xs, input logic [5:0] ys, input logic [5:0] z);
    in_vld = 1'b1;
    x_in   = x;
    y_in   = y;
    wait_accept(1'b1);
    if (in_rdy) push_const(x, y, xs, ys, z);
    @(posedge clk); #1;
    in_vld = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_out_vld"}, out_vld, 0);
    chk({tag, "_x"}, x_out, 0);
    chk({tag, "_y"}, y_out, 0);
    chk({tag, "_z"}, z_out, 0);
    chk({tag, "_cnt"}, cnt_out, 0);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_vld   = 1'b0;
    seed_vld = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_rdy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    m_s   = SEED;
    m_cnt = '0;
    @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk); #1;
  endtask

  // Monitor: every completed output handshake is popped and compared.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_vld && out_rdy) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", out_vld, 0);
        end else begin
          e = sb.pop_front();
          chk("x_shares", x_out, e.xs);
          chk("y_shares", y_out, e.ys);
          chk("z_rand", z_out, e.z);
          chk("op_cnt", cnt_out, e.cnt);
          chk("x_recombine", x_out[1:0] ^ x_out[3:2] ^ x_out[5:4], e.xi);
          chk("y_recombine", y_out[1:0] ^ y_out[3:2] ^ y_out[5:4], e.yi);
        end
      end
    end
  end

  initial begin
    do_reset();

    // First two accepts from SEED=1, then s=3.
    out_rdy = 1'b1;
    send_const(2'b11, 2'b10, 6'b000110, 6'b000010, 6'b000000);
    send_const(2'b00, 2'b01, 6'b001111, 6'b000001, 6'b000000);

    // Stall for five cycles with a new pair waiting.
    send(2'b10, 2'b11, 1'b1);
    out_rdy = 1'b0;
    in_vld  = 1'b1;
    x_in    = 2'b01;
    y_in    = 2'b10;
    repeat (5) begin
      @(negedge clk);
      chk("stall_out_vld", out_vld, 1);
      chk("stall_in_ready", in_rdy, 0);
      if (sb.size() > 0) begin
        chk("stall_x_hold", x_out, sb[0].xs);
        chk("stall_y_hold", y_out, sb[0].ys);
        chk("stall_z_hold", z_out, sb[0].z);
      end
      @(posedge clk); #1;
    end
    out_rdy = 1'b1;
    wait_accept(1'b1);
    if (in_rdy) push_model(2'b01, 2'b10);
    @(posedge clk); #1;
    in_vld = 1'b0;

    // Stream all 16 pairs back to back from a fresh reset.
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    out_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(i[3:2], i[1:0], 1'b1);
    end
    @(negedge clk);
    chk("stream_cnt", cnt_out, 16);
    @(posedge clk); #1;

    // Reseed with zero alongside a valid pair: blocked that cycle, SEED reloaded.
    repeat (2) @(posedge clk);
    #1;
    seed_vld = 1'b1;
    seed_dat = 32'd0;
    in_vld   = 1'b1;
    x_in     = 2'b11;
    y_in     = 2'b01;
    @(negedge clk);
    chk("reseed_in_ready", in_rdy, 0);
    @(posedge clk); #1;
    seed_vld = 1'b0;
    m_s      = SEED;
    send(2'b11, 2'b01, 1'b1);

    // Reseed with a pending stalled output: output stays put.
    out_rdy  = 1'b0;
    seed_vld = 1'b1;
    seed_dat = 32'hA5A5_1234;
    @(negedge clk);
    chk("reseed2_in_ready", in_rdy, 0);
    chk("reseed2_out_vld", out_vld, 1);
    if (sb.size() > 0) chk("reseed2_x_hold", x_out, sb[0].xs);
    @(posedge clk); #1;
    seed_vld = 1'b0;
    m_s      = 32'hA5A5_1234;
    out_rdy  = 1'b1;
    send(2'b10, 2'b01, 1'b1);
    send(2'b01, 2'b11, 1'b1);

    // Reset while a stalled output is pending.
    out_rdy = 1'b0;
    @(negedge clk);
    chk("pre_rst_out_vld", out_vld, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", in_rdy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    m_s   = SEED;
    m_cnt = '0;
    @(negedge clk);
    check_zero_outputs("midrst");
    @(posedge clk); #1;
    out_rdy = 1'b1;
    send_const(2'b11, 2'b10, 6'b000110, 6'b000010, 6'b000000);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gf2_mask_share_gen.md
GF2_MASK_SHARE_GEN -- requirements
Module: gf2_mask_share_gen

Interface
REQ-001 SHALL have parameter SHARES, default 3, number of output shares; legal range 2..4.
REQ-002 SHALL have parameter SEED, default 32'h0000_0001, LFSR reset and fallback value; nonzero.
REQ-003 SHALL have port ClkxCI, input, 1 bit, single clock; all state updates on its rising edge.
REQ-004 SHALL have port RstxRI, input, 1 bit, reset; one clock, synchronous, active-high.
REQ-005 SHALL have port InValidxSI, input, 1 bit, unmasked operand pair valid.
REQ-006 SHALL have port InReadyxSO, output, 1 bit, operand pair accepted when high together with InValidxSI.
REQ-007 SHALL have ports XxDI and YxDI, input, 2 bits each, unmasked GF(2^2) operands.
REQ-008 SHALL have port SeedValidxSI, input, 1 bit, reseed request.
REQ-009 SHALL have port SeedxDI, input, 32 bits, reseed value.
REQ-010 SHALL have port OutValidxSO, output, 1 bit, shared operands valid.
REQ-011 SHALL have port OutReadyxSI, input, 1 bit, downstream DOM multiplier accepts.
REQ-012 SHALL have ports _XxDO and _YxDO, output, 2*SHARES bits each; share i occupies bits [2i+1:2i].
REQ-013 SHALL have port _ZxDO, output, SHARES*(SHARES-1) bits, fresh DOM randomness aligned with the shares.
REQ-014 SHALL have port OpCntxDO, output, 16 bits, count of accepted operand pairs.

Function
REQ-015 SHALL hold a 32-bit LFSR s; one step: s <= {s[30:0], s[31]^s[21]^s[1]^s[0]}.
REQ-016 SHALL allocate random bits from the current s at accept: X masks s[2(SHARES-1)-1:0]; Y masks the next 2(SHARES-1) bits; _Z the next SHARES*(SHARES-1) bits.
REQ-017 SHALL assign X mask pair k (k=1..SHARES-1) to share k, and share 0 = XxDI XOR all X masks; Y likewise.
REQ-018 SHALL step the LFSR exactly once per accepted operand pair and never otherwise, except on reseed.
REQ-019 SHALL drive InReadyxSO = !SeedValidxSI && (!OutValidxSO || OutReadyxSI), combinationally.
REQ-020 SHALL register shares, _Z and OutValidxSO one cycle after accept; latency exactly 1 cycle.
REQ-021 SHALL hold all outputs stable while OutValidxSO=1 and OutReadyxSI=0.
REQ-022 SHALL clear OutValidxSO after a handshake with no new accept in the same cycle; a same-cycle accept keeps it high with new data, giving full throughput.
REQ-023 SHALL, on SeedValidxSI=1, load s <= SeedxDI, or SEED if SeedxDI=0; no accept in that cycle; a pending output is unaffected.
REQ-024 SHALL increment OpCntxDO by 1 per accept, wrapping 16'hFFFF -> 0.
REQ-025 SHALL never let the LFSR reach all-zero.

Reset
REQ-026 SHALL, when RstxRI=1 at a clock edge, set s=SEED, OutValidxSO=0, _XxDO=_YxDO=_ZxDO=0, OpCntxDO=0; any held output is discarded.
REQ-027 SHALL drive InReadyxSO=0 while RstxRI=1.
REQ-028 SHALL treat reset asserted mid-stall identically to reset from idle; no partial transaction survives.

Verification
REQ-029 SHALL cover SHARES=3, SEED=1: reset, accept X=2'b11, Y=2'b10 -> next cycle OutValidxSO=1, _XxDO=6'b000110, _YxDO=6'b000010, _ZxDO=0, OpCntxDO=1.
REQ-030 SHALL cover a second accept after REQ-029 (s=32'h3), X=2'b00 -> _XxDO=6'b001111; the XOR of all shares equals X in every case.
REQ-031 SHALL cover a stall: OutReadyxSI=0 for 5 cycles -> outputs frozen, InReadyxSO=0, LFSR unchanged; release -> the next pair is accepted.
REQ-032 SHALL cover back-to-back streaming of all 16 (X,Y) pairs with OutReadyxSI=1 -> 16 outputs on consecutive cycles, each recombining to its input, OpCntxDO=16.
REQ-033 SHALL cover reseed with SeedxDI=0 concurrent with InValidxSI=1 -> no accept that cycle, s=SEED, accept on the next cycle.
REQ-034 SHALL cover reset asserted while OutValidxSO=1 and stalled -> next cycle OutValidxSO=0, all outputs 0, OpCntxDO=0.
